// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared FSM states and nibble width for the serial adder
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// rtl/nibble_serial_adder_cla.sv - 4-bit carry-lookahead slice used once per nibble
module fourbitcla_claudelow
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic [NIB_W-1:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is flattened from generate/propagate terms; no ripple inside the slice.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign cout   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - handshaked adder that sums one nibble per cycle through a shared CLA slice
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic [NIB_W-1:0] w_slice_sum;
  logic             w_slice_cout;
  logic             w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = CALC;
      CALC:    if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Operands shift down one nibble per cycle so the slice always reads bits [3:0].
  fourbitcla_claudelow u_cla (
    .a    (r_a[NIB_W-1:0]),
    .b    (r_b[NIB_W-1:0]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        CALC: begin
          r_sum[r_idx*NIB_W +: NIB_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          r_a     <= r_a >> NIB_W;
          r_b     <= r_b >> NIB_W;
          r_idx   <= r_idx + 1'b1;
          // On the top nibble, bit 3 of each shifted operand is the original MSB.
          if (w_last) begin
            r_ovf <= (r_a[NIB_W-1] == r_b[NIB_W-1]) &&
                     (w_slice_sum[NIB_W-1] != r_a[NIB_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_carry;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench with an arithmetic reference model
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;
  logic [W+1:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {(x[W-1] == y[W-1]) && (t[W-1] != x[W-1]), t[W], t[W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic [W-1:0] s, input logic c, input logic o);
    chk({name, "_sum"}, {16'b0, sum}, {16'b0, s});
    chk({name, "_cout"}, {31'b0, cout}, {31'b0, c});
    chk({name, "_ovf"}, {31'b0, ovf}, {31'b0, o});
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    exp_q.push_back(model(x, y, c));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      chk("ready_while_valid", {31'b0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        chk("scoreboard", {14'b0, ovf, cout, sum}, {14'b0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [W-1:0] h_sum;
    logic         h_cout;
    logic         h_ovf;

    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0001;
    cin = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk_res("reset", 16'h0000, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("no_accept_during_rst", {30'b0, out_valid, in_ready}, 32'd1);

    chk("model_pin_ffff", {14'b0, model(16'hFFFF, 16'h0001, 1'b0)}, {14'b0, 2'b01, 16'h0000});
    chk("model_pin_7fff", {14'b0, model(16'h7FFF, 16'h0001, 1'b0)}, {14'b0, 2'b10, 16'h8000});

    send(16'hFFFF, 16'h0001, 1'b0);
    wait_result(lat);
    chk("latency", lat, 32'd4);
    chk_res("ffff_plus_1", 16'h0000, 1'b1, 1'b0);

    send(16'h7FFF, 16'h0001, 1'b0);
    wait_result(lat);
    chk_res("pos_ovf", 16'h8000, 1'b0, 1'b1);

    send(16'h8000, 16'h8000, 1'b0);
    wait_result(lat);
    chk_res("neg_ovf", 16'h0000, 1'b1, 1'b1);

    // Backpressure: result must hold for as long as out_ready stays low.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'h0F0F, 16'h00F1, 1'b1);
    wait_result(lat);
    chk("latency_ripple", lat, 32'd4);
    chk_res("ripple", 16'h1001, 1'b0, 1'b0);
    h_sum = sum;
    h_cout = cout;
    h_ovf = ovf;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold_stable", {14'b0, ovf, cout, sum}, {14'b0, h_ovf, h_cout, h_sum});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("release_out_valid", {31'b0, out_valid}, 32'd0);

    // New operands offered while busy must be ignored.
    send(16'hABCD, 16'h1111, 1'b0);
    a = 16'h1234;
    b = 16'h1111;
    cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(lat);
    chk_res("ignore_busy", 16'hBCDE, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("after_hs_in_ready", {31'b0, in_ready}, 32'd1);
    send(16'h1234, 16'h1111, 1'b0);
    wait_result(lat);
    chk_res("second_op", 16'h2345, 1'b0, 1'b0);

    // Abort mid-calculation at idx=2.
    send(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk_res("abort", 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'b0, out_valid}, 32'd0);
    end
    send(16'h0001, 16'h0001, 1'b0);
    wait_result(lat);
    chk("latency_after_abort", lat, 32'd4);
    chk_res("after_abort", 16'h0002, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand width in bits; legal values are multiples of 4 with a minimum of 4.
REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A (two's complement or unsigned).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  A+B+cin modulo 2^WIDTH.
- cout  out  1  unsigned carry-out.
- ovf  out  1  signed overflow.

Function
REQ-003 SHALL use an FSM with states IDLE, CALC and DONE; reset state SHALL be IDLE.
REQ-004 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-005 SHALL accept operands on a clock edge where the state is IDLE and in_valid=1.
- On that edge it SHALL latch a, b and cin.
- On that edge it SHALL clear the nibble index to 0 and enter CALC.
REQ-006 In CALC, each cycle SHALL add nibble[idx] of A, nibble[idx] of B and the running carry through one 4-bit CLA slice.
- The first cycle SHALL use the latched cin as the running carry.
- Each cycle SHALL register the 4-bit result into sum[4*idx+3:4*idx].
- Each cycle SHALL register the slice carry-out as the new running carry.
- Each cycle SHALL increment idx.
REQ-007 SHALL leave CALC after the cycle with idx=WIDTH/4-1 and enter DONE.
- Latency SHALL be WIDTH/4 cycles from the acceptance edge to the first out_valid=1 cycle (4 cycles at WIDTH=16).
REQ-008 In DONE, cout SHALL equal the final carry.
REQ-009 In DONE, ovf SHALL be 1 iff the latched A MSB equals the latched B MSB and sum MSB differs from them.
REQ-010 In DONE, sum, cout and ovf SHALL hold stable while out_ready=0, for any number of cycles.
REQ-011 On an edge where the state is DONE and out_ready=1, SHALL return to IDLE.
- in_ready SHALL therefore rise in the following cycle.
- There is no same-cycle turnaround.
REQ-012 SHALL ignore in_valid and the operand inputs in CALC and DONE; operands latched at acceptance SHALL NOT be disturbed.
REQ-013 SHALL hold sum at its last value outside DONE; out_valid is the only qualifier.
REQ-014 SHALL wrap sum modulo 2^WIDTH; the carry out of the top bit appears only on cout.

Reset
REQ-015 When rst=1 at a rising edge, SHALL set:
- state to IDLE
- idx=0
- running carry=0
- sum=0, cout=0, ovf=0
- out_valid=0, in_ready=1 (from the next cycle)
REQ-016 Reset SHALL take priority over every handshake.
- A reset asserted mid-CALC or in DONE SHALL abort the operation with no out_valid pulse.
- in_valid=1 in the same cycle as rst=1 SHALL NOT be accepted.
REQ-017 The block SHALL contain no asynchronous reset paths.

Structure
REQ-018 A shared package SHALL hold:
- the FSM state enumeration (IDLE, CALC, DONE)
- the nibble width constant NIB_W=4
REQ-019 SHALL instantiate exactly one fourbitcla_claudelow as the 4-bit CLA slice (ports a, b, cin, sum, cout), with no behavioural "+" on operands.
REQ-020 The datapath SHALL consist of one operand shift or index-mux register pair, one carry flop and one sum register.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- a=16'hFFFF, b=16'h0001, cin=0 -> out_valid on the 4th cycle after acceptance; sum=16'h0000, cout=1, ovf=0.
- a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; a=16'h8000, b=16'h8000, cin=0 -> sum=16'h0000, cout=1, ovf=1.
- a=16'h0F0F, b=16'h00F1, cin=1 -> sum=16'h1001, cout=0, ovf=0 (carry ripples across nibble boundaries).
- Hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and sum/cout/ovf unchanged all 10 cycles; in_ready=0 throughout.
- Assert in_valid with new operands (16'h1234, 16'h1111) during CALC -> ignored, and the original result is delivered; after handshake, in_ready=1 and a second op 16'h1234+16'h1111+0 gives 16'h2345.
- Assert rst for one cycle at CALC idx=2 -> no out_valid; next cycle IDLE with in_ready=1, sum=0, cout=0, ovf=0; a subsequent 16'h0001+16'h0001 gives 16'h0002.
